// File: rtl/branch_predictor_pkg.sv
// Shared branch definitions: predictor counter states, default sizing,
// and the branch condition opcodes used by the condition generator.
package branch_predictor_pkg;

  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_TAG_W   = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5
  } branch_op_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Two-bit saturating direction counter next-state logic.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e state_i,
  input  logic    taken_i,
  output bp_ctr_e next_o
);

  always_comb begin
    next_o = state_i;
    case (state_i)
      SNT:     next_o = taken_i ? WNT : SNT;
      WNT:     next_o = taken_i ? WT  : SNT;
      WT:      next_o = taken_i ? ST  : WNT;
      ST:      next_o = taken_i ? ST  : WT;
      default: next_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with 2-bit counters and
// stored targets, one-cycle registered prediction, update on branch resolve.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned TAG_W   = BP_TAG_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pred_valid_i,
  input  logic [31:0] pred_pc_i,
  input  logic        flush_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_LSB = IDX_W + 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  bp_ctr_e            ctr_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] p_idx, u_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             p_hit, p_taken, u_hit;
  logic [1:0]       p_ctr;
  logic [31:0]      p_target;
  bp_ctr_e          u_ctr_next;
  logic             unused_upd_pc_bits;

  assign p_idx = pred_pc_i[IDX_W+1:2];
  assign p_tag = pred_pc_i[TAG_LSB +: TAG_W];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[TAG_LSB +: TAG_W];

  assign unused_upd_pc_bits = ^{upd_pc_i[1:0], upd_pc_i[31:TAG_LSB+TAG_W]};

  // Lookup reads the pre-update array, so a same-cycle update to the
  // same entry only becomes visible to the following prediction.
  assign p_hit    = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign p_ctr    = ctr_q[p_idx];
  assign p_taken  = p_hit && p_ctr[1];
  assign p_target = p_taken ? tgt_q[p_idx] : pred_pc_i + 32'd4;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  bp_sat_counter u_sat_counter (
    .state_i (ctr_q[u_idx]),
    .taken_i (upd_taken_i),
    .next_o  (u_ctr_next)
  );

  // Direction/target hold their last value while no prediction is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
    end else begin
      pred_valid_o <= pred_valid_i & ~flush_i;
      if (pred_valid_i && !flush_i) begin
        pred_taken_o  <= p_taken;
        pred_target_o <= p_target;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      ctr_q   <= '{default: WNT};
      tgt_q   <= '{default: '0};
    end else if (upd_valid_i) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_next;
        if (upd_taken_i) begin
          tgt_q[u_idx] <= upd_target_i;
        end
      end else begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target_i;
        if (upd_taken_i) begin
          ctr_q[u_idx] <= WT;
        end else begin
          ctr_q[u_idx] <= WNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 8;

  logic        clk;
  logic        rst;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        flush_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pred_valid_i  (pred_valid_i),
    .pred_pc_i     (pred_pc_i),
    .flush_i       (flush_i),
    .pred_valid_o  (pred_valid_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        fl;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        ev;
    logic        et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers, counter 0..3
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic t, input logic [31:0] tg);
    checks++;
    if (pred_valid_o !== v || pred_taken_o !== t || pred_target_o !== tg) begin
      failures++;
      $display("FAIL %s: got valid=%0b taken=%0b target=%08h, expected valid=%0b taken=%0b target=%08h",
               name, pred_valid_o, pred_taken_o, pred_target_o, v, t, tg);
    end
  endtask

  task automatic add(input logic pv, input logic [31:0] ppc, input logic fl,
                     input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                     input logic ev, input logic et, input logic [31:0] etg);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.ev = ev; v.et = et; v.etg = etg;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic fl,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    pred_valid_i = pv; pred_pc_i = ppc; flush_i = fl;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utg;
  endtask

  function automatic int unsigned m_idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned m_tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | ($urandom << 14);
    return pc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = '0;
    end
  endtask

  initial begin
    logic        r_pv, r_fl, r_uv, r_ut, hit, tk, e_valid, e_taken;
    logic [31:0] r_ppc, r_upc, r_utg, e_tgt;
    int unsigned pi, ui;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    step();
    check("reset_state", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    //  pv    ppc            fl    uv    upc        ut    utg            ev    et    etg
    add(1'b1, 32'h100,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h104);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b1, 32'h200,       1'b0, 1'b0, 32'h104);
    add(1'b1, 32'h100,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b1, 32'h200);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b1, 32'h200,       1'b0, 1'b1, 32'h200);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b1, 32'h200,       1'b0, 1'b1, 32'h200);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b1, 32'h200,       1'b0, 1'b1, 32'h200);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b0, 32'h999,       1'b0, 1'b1, 32'h200);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h100,   1'b0, 32'h999,       1'b0, 1'b1, 32'h200);
    add(1'b1, 32'h100,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h104);
    add(1'b1, 32'h100,       1'b0, 1'b1, 32'h100,   1'b1, 32'h300,       1'b1, 1'b0, 32'h104);
    add(1'b1, 32'h100,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b1, 32'h300);
    add(1'b1, 32'h4100,      1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b1, 32'h300);
    add(1'b1, 32'h140,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h144);
    add(1'b0, 32'h0,         1'b0, 1'b1, 32'h140,   1'b0, 32'h500,       1'b0, 1'b0, 32'h144);
    add(1'b1, 32'h100,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h104);
    add(1'b1, 32'h140,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h144);
    add(1'b1, 32'h140,       1'b1, 1'b1, 32'h140,   1'b1, 32'h600,       1'b0, 1'b0, 32'h144);
    add(1'b1, 32'h140,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b1, 32'h600);
    add(1'b1, 32'hFFFFFFFC,  1'b0, 1'b0, 32'h0,     1'b0, 32'h0,         1'b1, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].fl, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg);
      step();
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, vecs[i].etg);
    end

    // Mid-stream reset: outputs clear asynchronously, coincident update is dropped
    drive(1'b1, 32'h140, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    check("pre_rst", 1'b1, 1'b1, 32'h600);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    #2;
    check("async_rst", 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h140, 1'b0, 1'b1, 32'h140, 1'b1, 32'h700);
    step();
    check("rst_held", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 32'h140, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    check("post_rst_miss", 1'b1, 1'b0, 32'h144);
    drive(1'b1, 32'h4100, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    check("post_rst_miss2", 1'b1, 1'b0, 32'h4104);

    // Randomized traffic against the reference model
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    e_taken = 1'b0;
    e_tgt   = '0;
    for (int n = 0; n < 400; n++) begin
      r_pv  = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 7) == 0);
      r_uv  = ($urandom_range(0, 1) != 0);
      r_ut  = ($urandom_range(0, 2) != 0);
      r_ppc = rand_pc();
      r_upc = ($urandom_range(0, 2) == 0) ? r_ppc : rand_pc();
      r_utg = $urandom & 32'hFFFFFFFC;

      pi  = m_idx_of(r_ppc);
      hit = m_valid[pi] && (m_tag[pi] == m_tag_of(r_ppc));
      tk  = hit && (m_ctr[pi] >= 2);
      e_valid = r_pv && !r_fl;
      if (e_valid) begin
        e_taken = tk;
        e_tgt   = tk ? m_tgt[pi] : r_ppc + 32'd4;
      end

      if (r_uv) begin
        ui = m_idx_of(r_upc);
        if (m_valid[ui] && (m_tag[ui] == m_tag_of(r_upc))) begin
          if (r_ut) begin
            m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            m_tgt[ui] = r_utg;
          end else begin
            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
          end
        end else begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = m_tag_of(r_upc);
          m_ctr[ui]   = r_ut ? 2 : 1;
          m_tgt[ui]   = r_utg;
        end
      end

      drive(r_pv, r_ppc, r_fl, r_uv, r_upc, r_ut, r_utg);
      step();
      check($sformatf("rand%0d", n), e_valid, e_taken, e_tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
